// File: rtl/dcw_axi_master_pkg.sv
// Shared definitions for the data-cache write-back AXI master: FSM encoding
// and the fixed AXI4 burst attributes of a 128-bit line written as 4x32-bit beats.
package dcw_axi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } dcw_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] DCW_AWLEN      = 8'd3;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dcw_axi_master_line_ser.sv
// Line serializer: shifts a 128-bit line and its 16-bit inverted byte mask out
// as four 32-bit W beats, tracking the beat index and completion of the last beat.
module dcw_line_ser (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] data_i,
  input  logic [15:0]  mask_i,
  input  logic         wready_i,
  output logic         wvalid_o,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         last_done_o
);

  logic [127:0] data_q;
  logic [15:0]  mask_q;
  logic [1:0]   cnt_q;
  logic         active_q;
  logic         done_q;
  logic         hs;
  logic         beat_last;

  assign hs        = active_q & wready_i;
  assign beat_last = (cnt_q == 2'd3);

  // Emptied slots fill with zero data and all-ones mask, so an idle bus shows wdata=0, wstrb=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      mask_q   <= '1;
      cnt_q    <= 2'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (load_i) begin
      data_q   <= data_i;
      mask_q   <= mask_i;
      cnt_q    <= 2'd0;
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (hs) begin
      data_q <= {32'h0, data_q[127:32]};
      mask_q <= {4'hF, mask_q[15:4]};
      cnt_q  <= cnt_q + 2'd1;
      if (beat_last) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

  assign wvalid_o    = active_q;
  assign wdata_o     = data_q[31:0];
  assign wstrb_o     = ~mask_q[3:0];
  assign wlast_o     = active_q & beat_last;
  assign last_done_o = done_q | (hs & beat_last);

endmodule

// File: rtl/dcw_axi_master.sv
// Data-cache write-back AXI4 master: one dirty line -> one 4-beat INCR burst.
// Define DCW_BRESP_CHECK_EN to latch a sticky bus error on non-OKAY BRESP.
module dcw_axi_master
  import dcw_axi_master_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcw_start_rq,
  input  logic [31:0]       dcw_in_addr,
  input  logic [15:0]       dcw_in_mask,
  input  logic [127:0]      dcw_in_data,
  output logic              dcw_finish_wresp,
  output logic              dcw_busy,
  output logic              dcw_bus_err,
  output logic [AWIDTH-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  if (BEATS != 4) begin : g_beats_check
    $error("dcw_axi_master: BEATS must be 4 (128-bit line over 32-bit bus)");
  end

  dcw_state_e        state_q;
  logic [AWIDTH-1:0] awaddr_q;
  logic              awvalid_q;
  logic              aw_done_q;
  logic              bready_q;
  logic              finish_q;
  logic              busy_q;
  logic              start_acc;
  logic              aw_hs;
  logic              last_done;

  assign start_acc = (state_q == ST_IDLE) & dcw_start_rq;
  assign aw_hs     = awvalid_q & awready;

  dcw_line_ser u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (start_acc),
    .data_i      (dcw_in_data),
    .mask_i      (dcw_in_mask),
    .wready_i    (wready),
    .wvalid_o    (wvalid),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .wlast_o     (wlast),
    .last_done_o (last_done)
  );

`ifdef DCW_BRESP_CHECK_EN
  logic err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      bready_q  <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DCW_BRESP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dcw_start_rq) begin
            awaddr_q  <= AWIDTH'(dcw_in_addr & 32'hFFFF_FFF0);
            awvalid_q <= 1'b1;
            aw_done_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          // AW and the final W beat may complete in the same cycle.
          if ((aw_done_q | aw_hs) && last_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
            state_q  <= ST_IDLE;
`ifdef DCW_BRESP_CHECK_EN
            if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign awaddr           = awaddr_q;
  assign awvalid          = awvalid_q;
  assign awlen            = DCW_AWLEN;
  assign awsize           = AXI_SIZE_4B;
  assign awburst          = AXI_BURST_INCR;
  assign bready           = bready_q;
  assign dcw_finish_wresp = finish_q;
  assign dcw_busy         = busy_q;
`ifdef DCW_BRESP_CHECK_EN
  assign dcw_bus_err      = err_q;
`else
  assign dcw_bus_err      = 1'b0;
`endif

endmodule

// File: doc/dcw_axi_master.md
# dcw_axi_master

Write-side bus master directly downstream of the data-cache LSU stage. Consumes the tiny write-bus request (128-bit dirty line + address + byte mask) issued on cache eviction or DC flush, and turns it into one AXI4 INCR burst of four 32-bit beats. Returns a one-cycle `dcw_finish_wresp` pulse when the write response has been taken, which the LSU uses to leave its write-back state or to step the flush counter.

## Interface
Parameters:
- `AWIDTH`, 32, AXI address width
- `BEATS`, 4, beats per line (fixed 128/32; not a free parameter, checked at elaboration)

Ports:
- `clk` in 1, single clock
- `rst` in 1, reset, synchronous, active-high
- `dcw_start_rq` in 1, request strobe; sampled only in IDLE
- `dcw_in_addr` in 32, line address; bits [3:0] ignored
- `dcw_in_mask` in 16, byte mask, 1 = byte NOT written
- `dcw_in_data` in 128, line data, bytes [3:0] = beat 0
- `dcw_finish_wresp` out 1, one-cycle completion pulse
- `dcw_busy` out 1, high whenever not IDLE
- `dcw_bus_err` out 1, sticky BRESP error (see Configuration)
- `awaddr` out AWIDTH; `awlen` out 8; `awsize` out 3; `awburst` out 2; `awvalid` out 1; `awready` in 1
- `wdata` out 32; `wstrb` out 4; `wlast` out 1; `wvalid` out 1; `wready` in 1
- `bresp` in 2; `bvalid` in 1; `bready` out 1

## Operation
- States: IDLE, XFER, RESP.
- IDLE: on `dcw_start_rq`=1 capture addr (bits [3:0] forced 0), mask, data into request registers; clear `aw_done`, beat counter = 0; go XFER.
- XFER: `awvalid` high until `awvalid&awready`, then `aw_done`=1 and `awvalid` low. `wvalid` high concurrently (W does not wait for AW). Each `wvalid&wready` advances beat counter (2 bits) and shifts next 32-bit word/4-bit strobe in. `wstrb` = ~mask bits of current beat. `wlast`=1 on beat 3 only. Leave to RESP when both `aw_done` and beat-3 handshake done (same-cycle completion of both allowed).
- RESP: `bready`=1. On `bvalid&bready` go IDLE; `dcw_finish_wresp` pulses the following cycle.
- Constants: `awlen`=3, `awsize`=3'b010, `awburst`=2'b01 (INCR), driven constantly.
- `dcw_start_rq` while busy: ignored (no queue); LSU guarantees one outstanding request. Bench asserts it never happens.
- `dcw_in_*` only need be valid in the start cycle.
- Mask all-ones: burst still issued with `wstrb`=0 on all beats.

## Timing
- Reset values: `awvalid`,`wvalid`,`wlast`,`bready`,`dcw_finish_wresp`,`dcw_busy`,`dcw_bus_err`=0; `awaddr`,`wdata`,`wstrb`=0; state IDLE.
- Start at cycle N -> `awvalid`,`wvalid`,`dcw_busy` high at N+1.
- Zero-wait slave: beats N+1..N+4, `wlast` at N+4, `bready` from N+5, `bvalid` at N+5 -> `dcw_finish_wresp` at N+6, `dcw_busy` low at N+6. Minimum request-to-finish: 6 cycles.
- Next start accepted in the cycle `dcw_finish_wresp` is high.
- `awvalid`/`wvalid` never drop before handshake; payload stable while valid and not ready.
- `rst` mid-burst: all outputs to reset values next edge, burst abandoned; permitted only with system-wide reset.

## Configuration
- `DCW_BRESP_CHECK_EN` defined: on B handshake with `bresp`!=2'b00, `dcw_bus_err` set and held until `rst`; finish pulse still issued.
- Not defined: `bresp` ignored, `dcw_bus_err` tied 0.

## Structure
- Shared package: state encoding (IDLE/XFER/RESP), AXI constants (`AXI_BURST_INCR`, `AXI_SIZE_4B`, `DCW_AWLEN`=8'd3), `AXI_RESP_OKAY`.
- One sub-module: `dcw_line_ser` — 128-bit data / 16-bit mask shift register plus 2-bit beat counter, producing `wdata`, `wstrb`, `wlast` and a `last_done` flag; top holds FSM and AW/B logic.

## Test plan
- Zero-wait slave, addr 0x0000_1238, data 0x44444444_33333333_22222222_11111111, mask 0 -> `awaddr`=0x0000_1230, beats 0x11111111..0x44444444, `wstrb`=4'hF, `wlast` on 4th, finish at N+6.
- Mask 16'h00F0 -> beat 1 `wstrb`=0, others 4'hF.
- `awready` held low 7 cycles, `wready` always high -> all 4 beats complete first, RESP entered only after AW handshake, single finish pulse.
- `wready` toggling 1/0 -> `wdata` stable during stalls, exactly 4 beats, correct order.
- With `DCW_BRESP_CHECK_EN`, `bresp`=2'b10 -> `dcw_bus_err`=1 sticky across next OK burst; cleared only by `rst`.
- `rst` asserted at beat 2 -> next cycle all valids 0, IDLE; new start then yields a clean full burst.
